generic__majn_filter: RTL and testbench

//  Parametrised, multi-channel majority-vote deglitch filter for asynchronous pad inputs (I2C SCL/SDA).
//  - Each channel: SYNC_STAGES flop synchroniser, then a DEPTH-deep sample window, then an N-of-DEPTH vote.
//  - Drives a registered, filtered level plus single-cycle rise/fall strobes into the I2C BERT protocol engine.
//  - Sequential, windowed generalisation of the combinational 5-input majority cell.
//

---
 rtl/generic__majn_filter.sv | 142 ++++++++++++++
 tb/tb_generic__majn_filter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/generic__majn_filter.sv
// generic__majn_filter: multi-channel majority-vote deglitch filter for asynchronous pad inputs.
// Each channel runs a SYNC_STAGES-deep synchroniser, then a DEPTH-bit sample window that shifts on
// sample_en, then an N-of-DEPTH vote that is registered into dout with single-cycle rise/fall strobes.
// Build option GENERIC_MAJN_HYST_EN: when defined, dout changes only once every window bit disagrees
// with the current dout (full-window hysteresis) instead of following the simple majority.
module generic__majn_filter #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DEPTH       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                flush,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned THR = (DEPTH + 1) / 2;

  // Reject illegal configurations at elaboration time.
  if ((DEPTH % 2) == 0 || DEPTH < 3 || DEPTH > 15) begin : g_bad_depth
    $error("generic__majn_filter: DEPTH must be odd and within 3..15");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("generic__majn_filter: CHANNELS must be within 1..8");
  end
  if (SYNC_STAGES > 3) begin : g_bad_sync
    $error("generic__majn_filter: SYNC_STAGES must be within 0..3");
  end

  logic [CHANNELS-1:0] s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = din;
  end else begin : g_sync
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    // Synchroniser chain: shifts every clk, untouched by sample_en and flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) begin
          sync_q[i] <= {CHANNELS{RESET_VAL}};
        end
      end else begin
        sync_q[0] <= din;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  logic [DEPTH-1:0]    win_q [CHANNELS];
  logic [DEPTH-1:0]    win_d [CHANNELS];
  logic [CHANNELS-1:0] vote;
  logic [CHANNELS-1:0] dout_q, dout_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

  // Window next state: flush reloads, otherwise shift in the synchronised sample on each tick.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      win_d[c] = win_q[c];
      if (flush) begin
        win_d[c] = {DEPTH{RESET_VAL}};
      end else if (sample_en) begin
        win_d[c] = {win_q[c][DEPTH-2:0], s[c]};
      end
    end
  end

`ifdef GENERIC_MAJN_HYST_EN
  // Hysteresis vote: flip only when the whole window opposes the current output.
  always_comb begin
    vote = dout_q;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (win_q[c] == {DEPTH{~dout_q[c]}}) begin
        vote[c] = ~dout_q[c];
      end
    end
  end
`else
  localparam logic [CW-1:0] ThrW = CW'(THR);

  logic [CW-1:0] ones [CHANNELS];

  // Majority vote: popcount of the current window against the half-plus-one threshold.
  always_comb begin
    vote = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      ones[c] = '0;
      for (int b = 0; b < int'(DEPTH); b++) begin
        ones[c] = ones[c] + CW'(win_q[c][b]);
      end
      vote[c] = (ones[c] >= ThrW);
    end
  end
`endif

  // Output next state: flush forces RESET_VAL and suppresses strobes even if dout changes.
  always_comb begin
    dout_d = vote;
    rise_d = vote & ~dout_q;
    fall_d = ~vote & dout_q;
    if (flush) begin
      dout_d = {CHANNELS{RESET_VAL}};
      rise_d = '0;
      fall_d = '0;
    end
  end

  // Window and output registers with asynchronous return to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        win_q[c] <= {DEPTH{RESET_VAL}};
      end
      dout_q <= {CHANNELS{RESET_VAL}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        win_q[c] <= win_d[c];
      end
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_generic__majn_filter.sv
// Self-checking bench for generic__majn_filter: directed steps plus randomized din/sample_en/flush,
// compared every clock against a queue-based reference model of the filter rules.
module tb_generic__majn_filter;

  localparam int unsigned CH = 2;
  localparam int unsigned D  = 5;
  localparam int unsigned SS = 2;
`ifdef GENERIC_MAJN_HYST_EN
  localparam bit HYST = 1'b1;
  localparam int LAT  = SS + D + 1;
`else
  localparam bit HYST = 1'b0;
  localparam int LAT  = SS + (D + 1) / 2 + 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          sample_en;
  logic          flush;
  logic [CH-1:0] din;
  logic [CH-1:0] dout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int checks = 0;
  int errors = 0;

  generic__majn_filter #(
    .CHANNELS   (CH),
    .DEPTH      (D),
    .SYNC_STAGES(SS),
    .RESET_VAL  (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_en(sample_en),
    .flush    (flush),
    .din      (din),
    .dout     (dout),
    .rise     (rise),
    .fall     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sample history kept as queues of channel vectors.
  logic [CH-1:0] m_sync[$];
  logic [CH-1:0] m_win[$];
  logic [CH-1:0] e_dout, e_rise, e_fall;

  function automatic void m_reset();
    m_sync.delete();
    m_win.delete();
    for (int i = 0; i < int'(SS); i++) m_sync.push_back({CH{1'b1}});
    for (int i = 0; i < int'(D); i++) m_win.push_back({CH{1'b1}});
    e_dout = {CH{1'b1}};
    e_rise = '0;
    e_fall = '0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void m_step();
    logic [CH-1:0] smp;
    logic [CH-1:0] nd;
    int cnt;
    int opp;
    if (SS == 0) smp = din;
    else smp = m_sync[0];
    for (int c = 0; c < int'(CH); c++) begin
      cnt = 0;
      opp = 0;
      for (int k = 0; k < m_win.size(); k++) begin
        if (m_win[k][c]) cnt++;
        if (m_win[k][c] != e_dout[c]) opp++;
      end
      if (HYST) nd[c] = (opp == int'(D)) ? ~e_dout[c] : e_dout[c];
      else      nd[c] = (2 * cnt > int'(D));
    end
    if (flush) begin
      m_win.delete();
      for (int i = 0; i < int'(D); i++) m_win.push_back({CH{1'b1}});
      nd     = {CH{1'b1}};
      e_rise = '0;
      e_fall = '0;
    end else begin
      e_rise = nd & ~e_dout;
      e_fall = ~nd & e_dout;
      if (sample_en) begin
        m_win.push_back(smp);
        void'(m_win.pop_front());
      end
    end
    if (SS > 0) begin
      m_sync.push_back(din);
      void'(m_sync.pop_front());
    end
    e_dout = nd;
  endfunction

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: model advance, edge, then compare #1 later.
  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    check("dout", dout, e_dout);
    check("rise", rise, e_rise);
    check("fall", fall, e_fall);
  endtask

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b0;
    flush     = 1'b0;
    din       = 2'b00;
    m_reset();

    // 1) Reset state, then latency of a clean 1->0 step on both channels.
    #12;
    check("reset_dout", dout, 2'b11);
    check("reset_rise", rise, 2'b00);
    check("reset_fall", fall, 2'b00);
    rst_n     = 1'b1;
    sample_en = 1'b1;
    for (int n = 1; n <= LAT + 3; n++) begin
      cyc();
      check($sformatf("lat_fall_e%0d", n), fall, (n == LAT) ? 2'b11 : 2'b00);
    end
    check("lat_dout", dout, 2'b00);

    // 2) Glitches on ch0 from idle high: 2-clk low, then 3-clk low.
    din = 2'b11;
    repeat (LAT + 3) cyc();
    din = 2'b10; repeat (2) cyc();
    din = 2'b11; repeat (LAT + 4) cyc();
    check("glitch2_dout", dout, 2'b11);
    din = 2'b10; repeat (3) cyc();
    din = 2'b11; repeat (LAT + 6) cyc();

    // 6) Pattern with a single opposing sample inside a run of lows.
    foreach (din[c]) din[c] = 1'b0;
    din = 2'b00; repeat (3) cyc();
    din = 2'b11; cyc();
    din = 2'b00; repeat (LAT + 6) cyc();
    din = 2'b11; repeat (LAT + 3) cyc();

    // 3) Prescaled sampling: tick every 4th clk, step on ch1.
    din = 2'b01;
    for (int n = 0; n < 48; n++) begin
      sample_en = (n % 4 == 3);
      cyc();
    end
    // Freeze: no ticks, din toggling.
    sample_en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      din = CH'($urandom);
      cyc();
      check("freeze_dout", dout, 2'b01);
    end

    // 4) Flush from dout=00, with sample_en high on the same clk.
    sample_en = 1'b1;
    din = 2'b00;
    repeat (LAT + 4) cyc();
    flush = 1'b1;
    cyc();
    check("flush_dout", dout, 2'b11);
    check("flush_rise", rise, 2'b00);
    flush = 1'b0;
    repeat (LAT + 3) cyc();

    // 5) Async reset between edges with the window half-filled.
    din = 2'b11;
    repeat (LAT + 3) cyc();
    din = 2'b00;
    repeat (SS + 2) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 2'b11);
    check("arst_rise", rise, 2'b00);
    check("arst_fall", fall, 2'b00);
    m_reset();
    din = 2'b11;
    #1 rst_n = 1'b1;
    repeat (LAT + 3) cyc();

    // Randomized traffic: slowly toggling din, mixed tick rates, occasional flush.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if ($urandom_range(0, 3) == 0) din[c] = ~din[c];
      end
      if (n < 750) sample_en = ($urandom_range(0, 3) != 0);
      else         sample_en = (n % 3 == 0);
      flush = ($urandom_range(0, 49) == 0);
      cyc();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
